// File: rtl/shift_seq_pkg.sv
// Shared types and register-mode encodings for the shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // {l,r} encodings understood by the universal shift register
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that stops at zero and flags the terminal value 1.
module seq_down_counter #(
  parameter int CNT_W = 4
) (
  input  logic             c,
  input  logic             nrst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             one
);

  always_ff @(posedge c or negedge nrst) begin
    if (!nrst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign one = (cnt == CNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer for an 8-bit universal shift register: optional load,
// then a counted run of fill/rotate shifts, streaming out departing bits.
//
// state | meaning
// IDLE  | ready for a command; register held
// LOAD  | parallel-load latched data
// SHIFT | one shift per cycle until the counter reaches 1
// DONE  | one-cycle completion pulse; q holds the result
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             c,
  input  logic             nrst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic             cmd_dir,
  input  logic             cmd_rot,
  input  logic             cmd_fill,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [W-1:0]     cmd_data,
  output logic             l,
  output logic             r,
  output logic             i,
  output logic [W-1:0]     d,
  input  logic [W-1:0]     q,
  output logic             so,
  output logic             so_valid,
  output logic             done
);

  state_t           state, state_nxt;
  logic             dir_q, rot_q, fill_q;
  logic [W-1:0]     data_q;
  logic [1:0]       mode;
  logic             cnt_load, cnt_dec, cnt_one;
  logic [CNT_W-1:0] cnt;
  logic             depart;

  always_ff @(posedge c or negedge nrst) begin
    if (!nrst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Command fields are captured only on the handshake, so later cmd_* wiggles are ignored
  always_ff @(posedge c or negedge nrst) begin
    if (!nrst) begin
      dir_q  <= 1'b0;
      rot_q  <= 1'b0;
      fill_q <= 1'b0;
      data_q <= '0;
    end else if (cmd_valid && cmd_ready) begin
      dir_q  <= cmd_dir;
      rot_q  <= cmd_rot;
      fill_q <= cmd_fill;
      data_q <= cmd_data;
    end
  end

  seq_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .c        (c),
    .nrst     (nrst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cmd_cnt),
    .cnt      (cnt),
    .one      (cnt_one)
  );

  assign depart = dir_q ? q[W-1] : q[0];

  always_comb begin
    state_nxt = state;
    mode      = MODE_HOLD;
    cmd_ready = 1'b0;
    so_valid  = 1'b0;
    done      = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    i         = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cnt_load = 1'b1;
          if (cmd_load)
            state_nxt = LOAD;
          else if (cmd_cnt != '0)
            state_nxt = SHIFT;
          else
            state_nxt = DONE;
        end
      end
      LOAD: begin
        mode      = MODE_LOAD;
        state_nxt = (cnt != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        mode     = dir_q ? MODE_SHL : MODE_SHR;
        so_valid = 1'b1;
        i        = rot_q ? depart : fill_q;
        cnt_dec  = 1'b1;
        if (cnt_one)
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign {l, r} = mode;
  assign d      = data_q;
  assign so     = depart;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer driving a behavioural universal shift register,
// checked against an arithmetic model of each command's effect.
module tb_shift_sequencer;

  logic       c = 1'b0;
  logic       nrst;
  logic       cmd_valid, cmd_ready, cmd_load, cmd_dir, cmd_rot, cmd_fill;
  logic [3:0] cmd_cnt;
  logic [7:0] cmd_data;
  logic       l, r, i, so, so_valid, done;
  logic [7:0] d, q;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] q_model;

  shift_sequencer #(.W(8), .CNT_W(4)) dut (
    .c(c), .nrst(nrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_dir(cmd_dir), .cmd_rot(cmd_rot),
    .cmd_fill(cmd_fill), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
    .l(l), .r(r), .i(i), .d(d), .q(q),
    .so(so), .so_valid(so_valid), .done(done)
  );

  always #5 c = ~c;

  // universal shift register (no reset)
  always @(posedge c) begin
    case ({l, r})
      2'b01:   q <= {i, q[7:1]};
      2'b10:   q <= {q[6:0], i};
      2'b11:   q <= d;
      default: q <= q;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // register value after k shifts of v
  function automatic logic [7:0] apply(input logic [7:0] v, input bit dr, input bit rt,
                                       input bit fl, input int k);
    logic [15:0] w;
    logic [7:0]  m, body, pad;
    int s;
    if (rt) begin
      s = k % 8;
      w = {v, v};
      return dr ? w[15-s -: 8] : w[s +: 8];
    end
    if (k >= 8) return {8{fl}};
    m = 8'hFF;
    if (dr) begin
      body = v << k;
      pad  = ~(m << k);
    end else begin
      body = v >> k;
      pad  = ~(m >> k);
    end
    return body | (fl ? pad : 8'h00);
  endfunction

  // bit leaving the register on shift number j (0-based)
  function automatic logic exp_so(input logic [7:0] v, input bit dr, input bit rt,
                                  input bit fl, input int j);
    int b;
    if (!rt && j >= 8) return fl;
    b = j % 8;
    return v[dr ? 7 - b : b];
  endfunction

  task automatic do_cmd(input bit ld, input bit dr, input bit rt, input bit fl,
                        input int cn, input logic [7:0] dt);
    logic [7:0] base;
    int exp_done, j;
    base     = ld ? dt : q_model;
    exp_done = 1 + int'(ld) + cn;
    @(negedge c);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_dir   = dr;
    cmd_rot   = rt;
    cmd_fill  = fl;
    cmd_cnt   = 4'(cn);
    cmd_data  = dt;
    chk("ready_idle", cmd_ready, 1'b1);
    @(posedge c);
    for (int n = 1; n <= exp_done; n++) begin
      @(negedge c);
      if (n == 1) begin
        cmd_valid = 1'b0;
        cmd_load  = 1'($urandom);
        cmd_dir   = 1'($urandom);
        cmd_rot   = 1'($urandom);
        cmd_fill  = 1'($urandom);
        cmd_cnt   = 4'($urandom);
        cmd_data  = 8'($urandom);
      end
      if (n == exp_done) begin
        chk("mode_done", {l, r}, 2'b00);
        chk("done", done, 1'b1);
        chk("ready_done", cmd_ready, 1'b0);
        chk("so_valid_done", so_valid, 1'b0);
        chk("q_final", q, apply(base, dr, rt, fl, cn));
      end else if (ld && n == 1) begin
        chk("mode_load", {l, r}, 2'b11);
        chk("d_load", d, dt);
        chk("so_valid_load", so_valid, 1'b0);
        chk("done_early", done, 1'b0);
      end else begin
        j = n - 1 - int'(ld);
        chk("mode_shift", {l, r}, dr ? 2'b10 : 2'b01);
        chk("so_valid", so_valid, 1'b1);
        chk("so", so, exp_so(base, dr, rt, fl, j));
        chk("q_shift", q, apply(base, dr, rt, fl, j));
        chk("done_early", done, 1'b0);
      end
    end
    q_model = apply(base, dr, rt, fl, cn);
    @(negedge c);
    chk("ready_after", cmd_ready, 1'b1);
    chk("done_after", done, 1'b0);
    chk("mode_after", {l, r}, 2'b00);
  endtask

  initial begin
    logic [7:0] dt;
    bit         rt, fl;
    nrst      = 1'b0;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_dir   = 1'b0;
    cmd_rot   = 1'b0;
    cmd_fill  = 1'b0;
    cmd_cnt   = 4'd0;
    cmd_data  = 8'd0;
    q_model   = 8'd0;

    #12;
    chk("rst_mode", {l, r}, 2'b00);
    chk("rst_i", i, 1'b0);
    chk("rst_d", d, 8'h00);
    chk("rst_so_valid", so_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge c);
    nrst = 1'b1;
    #1 chk("rst_ready", cmd_ready, 1'b1);

    do_cmd(1, 0, 0, 0, 0, 8'hA5);
    chk("load_only_q", q, 8'hA5);
    do_cmd(1, 0, 0, 1, 3, 8'hB4);
    chk("fill_q", q_model, 8'hF6);
    do_cmd(1, 1, 1, 0, 9, 8'h81);
    chk("rot_q", q_model, 8'h03);

    // two zero-length commands with the minimum gap
    do_cmd(0, 0, 0, 0, 0, 8'h00);
    do_cmd(0, 1, 1, 1, 0, 8'hFF);
    chk("zero_len_q", q, 8'h03);

    do_cmd(1, 0, 0, 0, 0, 8'h5A);
    do_cmd(0, 1, 0, 0, 15, 8'h00);
    chk("overflow_q", q, 8'h00);

    // reset during the second shift of a command
    dt = 8'($urandom);
    rt = 1'($urandom);
    fl = 1'($urandom);
    @(negedge c);
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_dir = 1'b0; cmd_rot = rt;
    cmd_fill = fl; cmd_cnt = 4'd5; cmd_data = dt;
    @(posedge c);
    @(negedge c);
    cmd_valid = 1'b0;
    @(negedge c);
    @(negedge c);
    chk("pre_rst_mode", {l, r}, 2'b01);
    nrst = 1'b0;
    #1;
    chk("abort_mode", {l, r}, 2'b00);
    chk("abort_so_valid", so_valid, 1'b0);
    chk("abort_i", i, 1'b0);
    chk("abort_done", done, 1'b0);
    repeat (2) begin
      @(negedge c);
      chk("abort_q", q, apply(dt, 0, rt, fl, 1));
      chk("abort_done", done, 1'b0);
    end
    nrst = 1'b1;
    #1 chk("abort_ready", cmd_ready, 1'b1);
    repeat (3) begin
      @(negedge c);
      chk("abort_no_done", done, 1'b0);
      chk("abort_hold", {l, r}, 2'b00);
    end
    q_model = apply(dt, 0, rt, fl, 1);

    for (int t = 0; t < 24; t++)
      do_cmd(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 15)), 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
